layer_prio_mixer: RTL
=====================

Name: layer_prio_mixer

Overview:
Parametrised, pipelined successor to the SNK-style layer-select/colour-bank PAL. It takes N layer pixel streams, drops transparent pens, and picks the winning layer under a CPU-programmable priority mode. It then outputs a palette index as {colour bank, pen}. The block sits between the layer generators (sprite/BG/FG) and the palette RAM address mux. Priority mode and bank-offset writes take effect only at vblank start, so a frame is never torn.

Parameters:
NUM_LAYERS, 3, number of input layers; index 0 = layer 0.
PIX_W, 7, pen bits per layer.
BANK_W, 3, colour-bank bits on output.
TRANSP_PEN, 7'h0F, pen value treated as transparent; compared on all PIX_W bits.
LID_W, $clog2(NUM_LAYERS+1), derived, layer-id width; value NUM_LAYERS = backdrop.

Ports:
clk  in  1  system clock
RESETn  in  1  asynchronous active-low reset
ce_pix  in  1  pixel clock enable; pipeline advances only when high
hblank  in  1  horizontal blank, aligned with pix_in
vblank  in  1  vertical blank, aligned with pix_in
pix_in  in  NUM_LAYERS*PIX_W  packed pens; layer i at [i*PIX_W +: PIX_W]
attr_in  in  NUM_LAYERS  per-layer bank attribute bit (odd/even bank select)
cpu_we  in  1  config write strobe, one clk wide
cpu_din  in  8  [1:0] priority mode, [2+:BANK_W] bank offset
col_out  out  BANK_W+PIX_W  {bank, pen} palette index
layer_out  out  LID_W  winning layer id
pix_valid  out  1  col_out is an active-display pixel
cfg_pending  out  1  a written config is waiting for vblank

Behaviour:
- Reset (RESETn low, async): col_out=0, layer_out=0, pix_valid=0, cfg_pending=0, pending and active mode=0, bank offset=0, all pipeline registers=0, vblank_d=0.
- Config handshake: cpu_we loads the pending register and sets cfg_pending. vblank_d is a registered vblank sampled every clk, independent of ce_pix. Rising edge (vblank & ~vblank_d) copies pending to active and clears cfg_pending.
- cpu_we in the same clk as the vblank rise: active gets the OLD pending value. The new value stays pending and cfg_pending stays 1 until the next vblank rise.
- Repeated writes before vblank: the last write wins.
- Stage 1 (on ce_pix): register pens, attr bits, blank = hblank|vblank, and opaque[i] = (pen_i != TRANSP_PEN).
- Stage 2 (on ce_pix): resolve the winner using active mode:
  mode 0: priority index ascending; layer 0 highest.
  mode 1: layers 0 and 1 swapped, rest ascending.
  mode 2: priority index descending; layer NUM_LAYERS-1 highest.
  mode 3: only layer NUM_LAYERS-1 is eligible; all others are treated as transparent.
- Winner w: bank = (2*w + attr_w + bank_offset) mod 2^BANK_W. col_out = {bank, pen_w}, layer_out = w.
- No opaque layer: backdrop. col_out = {all-ones bank, PIX_W'b0}, layer_out = NUM_LAYERS.
- Blank pixel: col_out=0, layer_out=0, pix_valid=0. Otherwise pix_valid=1.
- Latency: exactly 2 ce_pix-qualified cycles from pix_in to col_out. Outputs hold while ce_pix=0.
- Active-config changes apply to stage 2 from the next ce_pix after the transfer. Pixels already in stage 1 use the new mode; this is acceptable because the transfer happens in blank.
- Reset mid-frame clears the pipeline. The first two ce_pix pulses after release output blank (pix_valid=0).

Decomposition:
- Package layer_mix_pkg: mode encodings (MODE_ASC, MODE_SWAP01, MODE_DESC, MODE_LASTONLY), TRANSP_PEN default, backdrop-id helper.
- One sub-module, layer_prio_resolve: purely combinational. Inputs are the opaque vector and mode; outputs are the winner index and a found flag. The top level holds all state: config registers, vblank edge detect, and both pipeline stages.

Test Plan:
- Reset, ce_pix every 2nd clk, pens L0=0x05, L1=0x22, L2=0x33, attr=0, mode 0, offset 0 -> after 2 ce_pix: col_out={3'd0,7'h05}, layer_out=0, pix_valid=1.
- L0=0x0F (transparent), L1=0x22, attr1=1, mode 0 -> col_out={3'd3,7'h22}, layer_out=1.
- Write cpu_din=8'h0A (mode 2, offset 2) mid-line -> cfg_pending=1 and output unchanged. After vblank rise, cfg_pending=0. Pens 05/22/33 with attr=0 -> winner L2, bank=(4+0+2)=6, col_out={3'd6,7'h33}.
- All pens 0x0F -> col_out={3'b111,7'h00}, layer_out=3. With hblank=1 on the same pixel -> col_out=0, pix_valid=0.
- cpu_we (mode 3) in the same clk as the vblank rise, pending previously mode 1 -> active=mode 1 and cfg_pending stays 1. Next vblank rise -> active=mode 3, and only L2 is ever output.
- Assert RESETn low for 1 clk mid-line -> all outputs 0 at once (async). First 2 ce_pix after release -> pix_valid=0.

Source files
------------

// File: rtl/layer_mix_pkg.sv
// Shared definitions for the layer priority mixer: priority-mode encodings,
// the default transparent pen and the backdrop layer-id helper.
package layer_mix_pkg;

    typedef enum logic [1:0] {
        MODE_ASC      = 2'd0,
        MODE_SWAP01   = 2'd1,
        MODE_DESC     = 2'd2,
        MODE_LASTONLY = 2'd3
    } mode_t;

    localparam logic [6:0] TRANSP_PEN_DEFAULT = 7'h0F;

    // The backdrop is reported as the first id past the real layers.
    function automatic int unsigned backdrop_id(input int unsigned num_layers);
        return num_layers;
    endfunction

endpackage

// File: rtl/layer_prio_resolve.sv
// Combinational winner selection: walks the layers in the rank order implied
// by the priority mode and returns the first eligible opaque layer.
module layer_prio_resolve
    import layer_mix_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned LID_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic [NUM_LAYERS-1:0] opaque,
    input  mode_t                 mode,
    output logic [LID_W-1:0]      winner,
    output logic                  found
);

    // Maps a rank position (0 = highest priority) to a layer index.
    function automatic int unsigned layer_at(input int unsigned p, input mode_t m);
        case (m)
            MODE_SWAP01:              return (NUM_LAYERS > 1 && p < 2) ? (32'd1 - p) : p;
            MODE_DESC, MODE_LASTONLY: return NUM_LAYERS - 1 - p;
            default:                  return p;
        endcase
    endfunction

    logic [NUM_LAYERS-1:0] shifted;
    int unsigned           idx;

    always_comb begin
        winner  = LID_W'(backdrop_id(NUM_LAYERS));
        found   = 1'b0;
        shifted = '0;
        idx     = 0;
        for (int unsigned p = 0; p < NUM_LAYERS; p++) begin
            idx     = layer_at(p, mode);
            shifted = opaque >> idx;
            if (!found && shifted[0] &&
                (mode != MODE_LASTONLY || idx == NUM_LAYERS - 1)) begin
                winner = LID_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_prio_mixer.sv
// Layer priority mixer: two-stage pixel pipeline choosing the winning opaque
// layer and forming a {bank, pen} palette index; config latches at vblank start.
module layer_prio_mixer
    import layer_mix_pkg::*;
#(
    parameter int unsigned      NUM_LAYERS = 3,
    parameter int unsigned      PIX_W      = 7,
    parameter int unsigned      BANK_W     = 3,
    parameter logic [PIX_W-1:0] TRANSP_PEN = PIX_W'(TRANSP_PEN_DEFAULT),
    parameter int unsigned      LID_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic                        clk,
    input  logic                        RESETn,
    input  logic                        ce_pix,
    input  logic                        hblank,
    input  logic                        vblank,
    input  logic [NUM_LAYERS*PIX_W-1:0] pix_in,
    input  logic [NUM_LAYERS-1:0]       attr_in,
    input  logic                        cpu_we,
    input  logic [7:0]                  cpu_din,
    output logic [BANK_W+PIX_W-1:0]     col_out,
    output logic [LID_W-1:0]            layer_out,
    output logic                        pix_valid,
    output logic                        cfg_pending
);

    mode_t             pend_mode, act_mode;
    logic [BANK_W-1:0] pend_off, act_off;
    logic              vblank_d;
    logic              vb_rise;

    assign vb_rise = vblank & ~vblank_d;

    // A write coinciding with the vblank rise stays pending; the transfer
    // takes the value that was pending before the write.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            vblank_d    <= 1'b0;
            pend_mode   <= MODE_ASC;
            pend_off    <= '0;
            act_mode    <= MODE_ASC;
            act_off     <= '0;
            cfg_pending <= 1'b0;
        end else begin
            vblank_d <= vblank;
            if (vb_rise) begin
                act_mode <= pend_mode;
                act_off  <= pend_off;
            end
            if (cpu_we) begin
                pend_mode   <= mode_t'(cpu_din[1:0]);
                pend_off    <= cpu_din[2 +: BANK_W];
                cfg_pending <= 1'b1;
            end else if (vb_rise) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    logic [NUM_LAYERS-1:0][PIX_W-1:0] s1_pen;
    logic [NUM_LAYERS-1:0]            s1_attr;
    logic [NUM_LAYERS-1:0]            s1_opaque;
    logic                             s1_blank;
    logic                             s1_live;

    // s1_live marks stage 1 as holding a sampled pixel rather than reset state.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            s1_pen    <= '0;
            s1_attr   <= '0;
            s1_opaque <= '0;
            s1_blank  <= 1'b0;
            s1_live   <= 1'b0;
        end else if (ce_pix) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                s1_pen[i]    <= pix_in[i*PIX_W +: PIX_W];
                s1_opaque[i] <= (pix_in[i*PIX_W +: PIX_W] != TRANSP_PEN);
            end
            s1_attr  <= attr_in;
            s1_blank <= hblank | vblank;
            s1_live  <= 1'b1;
        end
    end

    logic [LID_W-1:0]  win;
    logic              found;
    logic [PIX_W-1:0]  pen_w;
    logic              attr_w;
    logic [BANK_W-1:0] bank_w;

    layer_prio_resolve #(
        .NUM_LAYERS (NUM_LAYERS),
        .LID_W      (LID_W)
    ) u_resolve (
        .opaque (s1_opaque),
        .mode   (act_mode),
        .winner (win),
        .found  (found)
    );

    always_comb begin
        pen_w  = '0;
        attr_w = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (LID_W'(i) == win) begin
                pen_w  = s1_pen[i];
                attr_w = s1_attr[i];
            end
        end
        bank_w = BANK_W'({win, 1'b0}) + BANK_W'(attr_w) + act_off;
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            col_out   <= '0;
            layer_out <= '0;
            pix_valid <= 1'b0;
        end else if (ce_pix) begin
            if (s1_blank || !s1_live) begin
                col_out   <= '0;
                layer_out <= '0;
                pix_valid <= 1'b0;
            end else if (found) begin
                col_out   <= {bank_w, pen_w};
                layer_out <= win;
                pix_valid <= 1'b1;
            end else begin
                col_out   <= {{BANK_W{1'b1}}, {PIX_W{1'b0}}};
                layer_out <= LID_W'(backdrop_id(NUM_LAYERS));
                pix_valid <= 1'b1;
            end
        end
    end

endmodule
